// File: rtl/gpio_exp_apb_pkg.sv
// Shared types and default sizing for the GPIO expander bank bus.
package gpio_exp_apb_pkg;

  localparam int DEF_BANK_ADDR  = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-request round-robin picker; on a tie the master not granted last wins.
module apb_rr_arb2 (
  input  logic       sclk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] pick
);

  logic last_m1;

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_m1 ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Reset to "master 1 served last" so master 0 takes the first tie.
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      last_m1 <= 1'b1;
    end else if (take && (req != 2'b00)) begin
      last_m1 <= pick[1];
    end
  end

endmodule

// File: rtl/apb_bank_arbiter.sv
// Two-master APB arbiter for the bank bus: one full transfer at a time,
// regenerated SETUP/ACCESS downstream, timeout terminates hung transfers.
module apb_bank_arbiter
  import gpio_exp_apb_pkg::*;
#(
  parameter int BANK_ADDR  = DEF_BANK_ADDR,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic [BANK_ADDR-1:0]  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pwdata,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_pslverr,
  input  logic [BANK_ADDR-1:0]  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pwdata,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_pslverr,
  output logic [BANK_ADDR-1:0]  s_psel,
  output logic                  s_penable,
  output logic                  s_pwrite,
  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pwdata,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  output logic [1:0]            gnt,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  apb_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [BANK_ADDR-1:0]  psel_q;
  logic [1:0]            req;
  logic [1:0]            pick;
  logic [BANK_ADDR-1:0]  win_psel;
  logic                  win_pwrite;
  logic [ADDR_WIDTH-1:0] win_paddr;
  logic [DATA_WIDTH-1:0] win_pwdata;
  logic                  finish;
  logic                  fin_err;
  logic [DATA_WIDTH-1:0] fin_data;
  logic                  unused_penable;

  // Master penable carries no information the arbiter needs.
  assign unused_penable = m0_penable ^ m1_penable;

  assign req = {(m1_psel != '0), (m0_psel != '0)};

  apb_rr_arb2 u_arb (
    .sclk   (sclk),
    .resetn (resetn),
    .req    (req),
    .take   (state == IDLE),
    .pick   (pick)
  );

  always_comb begin
    win_psel   = m0_psel;
    win_pwrite = m0_pwrite;
    win_paddr  = m0_paddr;
    win_pwdata = m0_pwdata;
    if (pick[1]) begin
      win_psel   = m1_psel;
      win_pwrite = m1_pwrite;
      win_paddr  = m1_paddr;
      win_pwdata = m1_pwdata;
    end
  end

  // Completion condition and the data/error reported back to the owner.
  always_comb begin
    finish   = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    case (state)
      SETUP: begin
        if (!$onehot(psel_q)) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      ACCESS: begin
        if (s_pready) begin
          finish   = 1'b1;
          fin_data = s_pwrite ? '0 : s_prdata;
        end else if (cnt == CNT_MAX) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      psel_q     <= '0;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      s_psel     <= '0;
      s_penable  <= 1'b0;
      s_pwrite   <= 1'b0;
      s_paddr    <= '0;
      s_pwdata   <= '0;
      m0_pready  <= 1'b0;
      m0_pslverr <= 1'b0;
      m0_prdata  <= '0;
      m1_pready  <= 1'b0;
      m1_pslverr <= 1'b0;
      m1_prdata  <= '0;
    end else begin
      m0_pready  <= 1'b0;
      m0_pslverr <= 1'b0;
      m0_prdata  <= '0;
      m1_pready  <= 1'b0;
      m1_pslverr <= 1'b0;
      m1_prdata  <= '0;
      if (finish) begin
        state      <= DONE;
        s_psel     <= '0;
        s_penable  <= 1'b0;
        s_pwrite   <= 1'b0;
        s_paddr    <= '0;
        s_pwdata   <= '0;
        m0_pready  <= gnt[0];
        m0_pslverr <= gnt[0] & fin_err;
        m0_prdata  <= gnt[0] ? fin_data : '0;
        m1_pready  <= gnt[1];
        m1_pslverr <= gnt[1] & fin_err;
        m1_prdata  <= gnt[1] ? fin_data : '0;
      end else begin
        case (state)
          IDLE: begin
            if (req != 2'b00) begin
              state  <= SETUP;
              gnt    <= pick;
              busy   <= 1'b1;
              cnt    <= '0;
              psel_q <= win_psel;
              // A malformed select never reaches the bank.
              if ($onehot(win_psel)) begin
                s_psel   <= win_psel;
                s_pwrite <= win_pwrite;
                s_paddr  <= win_paddr;
                s_pwdata <= win_pwdata;
              end
            end
          end
          SETUP: begin
            state     <= ACCESS;
            s_penable <= 1'b1;
          end
          ACCESS: begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
          DONE: begin
            state <= IDLE;
            gnt   <= 2'b00;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_bank_arbiter.sv
// Directed bench for apb_bank_arbiter with a small bank responder model.
module tb_apb_bank_arbiter;

  logic       sclk = 1'b0;
  logic       resetn;
  logic [1:0] m0_psel, m1_psel;
  logic       m0_penable, m1_penable, m0_pwrite, m1_pwrite;
  logic [2:0] m0_paddr, m1_paddr;
  logic [7:0] m0_pwdata, m1_pwdata, m0_prdata, m1_prdata;
  logic       m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [1:0] s_psel;
  logic       s_penable, s_pwrite, s_pready;
  logic [2:0] s_paddr;
  logic [7:0] s_pwdata, s_prdata;
  logic [1:0] gnt;
  logic       busy;

  logic       ws_mode;
  logic       pready_drv;
  logic [2:0] wcnt = 3'd0;
  logic [1:0] eg;
  int         checks = 0;
  int         errors = 0;

  always #5 sclk = ~sclk;

  apb_bank_arbiter dut (
    .sclk(sclk), .resetn(resetn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
    .s_pready(s_pready), .gnt(gnt), .busy(busy)
  );

  // Bank model: bank 0 reads 0x3C, bank 1 reads 0xC3; optional 3 wait states.
  always @(posedge sclk) begin
    if (s_penable) wcnt <= wcnt + 3'd1;
    else           wcnt <= 3'd0;
  end
  assign s_prdata = (s_psel == 2'b01) ? 8'h3C : (s_psel == 2'b10) ? 8'hC3 : 8'h00;
  assign s_pready = ws_mode ? (wcnt == 3'd3) : pready_drv;

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic [1:0] psel, input logic wr, input logic [2:0] addr,
                        input logic [7:0] data);
    m0_psel = psel; m0_pwrite = wr; m0_paddr = addr; m0_pwdata = data;
    m0_penable = (psel != 2'b00);
  endtask

  task automatic set_m1(input logic [1:0] psel, input logic wr, input logic [2:0] addr,
                        input logic [7:0] data);
    m1_psel = psel; m1_pwrite = wr; m1_paddr = addr; m1_pwdata = data;
    m1_penable = (psel != 2'b00);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; ws_mode = 1'b0; pready_drv = 1'b1;
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    set_m1(2'b00, 1'b0, 3'd0, 8'h00);
    #2;
    chk("rst_s_psel", s_psel, 0);
    chk("rst_s_penable", s_penable, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pready", {m1_pready, m0_pready}, 0);
    tick; resetn = 1'b1; tick;

    // Single zero-wait write from master 0
    set_m0(2'b01, 1'b1, 3'd3, 8'hA5);
    tick;
    chk("wr_setup_psel", s_psel, 2'b01);
    chk("wr_setup_penable", s_penable, 0);
    chk("wr_setup_gnt", gnt, 2'b01);
    chk("wr_setup_busy", busy, 1);
    chk("wr_setup_bus", {s_pwrite, s_paddr, s_pwdata}, {1'b1, 3'd3, 8'hA5});
    tick;
    chk("wr_access_penable", s_penable, 1);
    chk("wr_access_pready", m0_pready, 0);
    tick;
    chk("wr_done_pready", m0_pready, 1);
    chk("wr_done_err", m0_pslverr, 0);
    chk("wr_done_rdata", m0_prdata, 0);
    chk("wr_done_bus", {s_psel, s_penable}, 0);
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    tick;
    chk("wr_idle", {gnt, busy, m0_pready}, 0);

    // Simultaneous reads right after reset
    resetn = 1'b0; tick; resetn = 1'b1; tick;
    set_m0(2'b01, 1'b0, 3'd1, 8'h00);
    set_m1(2'b10, 1'b0, 3'd2, 8'h00);
    tick;
    chk("tie_gnt0", gnt, 2'b01);
    chk("tie_psel0", s_psel, 2'b01);
    tick;
    chk("tie_m1_wait_a", m1_pready, 0);
    tick;
    chk("tie_m0_pready", m0_pready, 1);
    chk("tie_m0_data", m0_prdata, 8'h3C);
    chk("tie_m1_wait_b", {m1_pready, m1_prdata}, 0);
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    tick;
    chk("tie_m1_wait_c", m1_pready, 0);
    tick;
    chk("tie_gnt1", gnt, 2'b10);
    chk("tie_psel1", s_psel, 2'b10);
    tick;
    tick;
    chk("tie_m1_pready", m1_pready, 1);
    chk("tie_m1_data", m1_prdata, 8'hC3);
    chk("tie_m1_err", m1_pslverr, 0);
    chk("tie_m0_quiet", m0_pready, 0);
    set_m1(2'b00, 1'b0, 3'd0, 8'h00);
    tick;

    // Hung bank: timeout after 16 ACCESS cycles
    pready_drv = 1'b0;
    set_m0(2'b01, 1'b0, 3'd1, 8'h00);
    tick;
    chk("to_setup_psel", s_psel, 2'b01);
    repeat (16) tick;
    chk("to_still_access", {s_penable, m0_pready}, 2'b10);
    tick;
    chk("to_pready", m0_pready, 1);
    chk("to_err", m0_pslverr, 1);
    chk("to_rdata", m0_prdata, 0);
    chk("to_psel_drop", {s_psel, s_penable}, 0);
    pready_drv = 1'b1;
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    tick;

    // Malformed select from master 1
    set_m1(2'b11, 1'b0, 3'd4, 8'h00);
    tick;
    chk("bad_no_psel", s_psel, 0);
    chk("bad_gnt", gnt, 2'b10);
    tick;
    chk("bad_pready", m1_pready, 1);
    chk("bad_err", m1_pslverr, 1);
    chk("bad_rdata", m1_prdata, 0);
    chk("bad_bus_quiet", {s_psel, s_penable}, 0);
    set_m1(2'b00, 1'b0, 3'd0, 8'h00);
    tick;

    // Continuous requests from both, 3 bank wait states
    ws_mode = 1'b1;
    set_m0(2'b01, 1'b0, 3'd1, 8'h00);
    set_m1(2'b10, 1'b0, 3'd2, 8'h00);
    for (int t = 0; t < 4; t++) begin
      eg = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick;
      chk("rr_gnt", gnt, eg);
      repeat (4) tick;
      chk("rr_wait", {m1_pready, m0_pready}, 0);
      tick;
      chk("rr_pready", {m1_pready, m0_pready}, eg);
      chk("rr_data", eg[0] ? m0_prdata : m1_prdata, eg[0] ? 8'h3C : 8'hC3);
      tick;
      chk("rr_idle", busy, 0);
    end
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    set_m1(2'b00, 1'b0, 3'd0, 8'h00);
    ws_mode = 1'b0;
    tick;

    // Reset pulsed in the middle of ACCESS
    pready_drv = 1'b0;
    set_m0(2'b01, 1'b0, 3'd1, 8'h00);
    tick;
    tick;
    chk("mr_in_access", s_penable, 1);
    resetn = 1'b0;
    #1;
    chk("mr_s_bus", {s_psel, s_penable}, 0);
    chk("mr_gnt_busy", {gnt, busy}, 0);
    tick;
    chk("mr_no_pready", {m1_pready, m0_pready}, 0);
    set_m1(2'b10, 1'b0, 3'd2, 8'h00);
    pready_drv = 1'b1;
    resetn = 1'b1;
    tick;
    chk("mr_tie_gnt", gnt, 2'b01);
    tick;
    tick;
    chk("mr_m0_pready", m0_pready, 1);
    chk("mr_m0_data", m0_prdata, 8'h3C);
    set_m0(2'b00, 1'b0, 3'd0, 8'h00);
    set_m1(2'b00, 1'b0, 3'd0, 8'h00);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
